// File: rtl/rgb_pkg.sv
// rgb_pkg: shared state encoding, colour bit layout and default sizing for the RGB PWM driver.
package rgb_pkg;

  localparam int DEF_PWM_W         = 4;
  localparam int DEF_FLASH_PERIODS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    FLASH = 2'd2
  } state_t;

  // Colour vectors are packed {red, green, blue}.
  typedef logic [2:0] rgb_t;
  localparam int R_IDX = 2;
  localparam int G_IDX = 1;
  localparam int B_IDX = 0;

  function automatic rgb_t rgb_gate(input rgb_t c, input logic on);
    return on ? c : 3'b000;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if: control/colour inputs and LED drive outputs of the RGB PWM driver.
interface rgb_pwm_driver_if
  import rgb_pkg::*;
#(
  parameter int PWM_W = DEF_PWM_W
);

  logic             enable;
  logic             red;
  logic             green;
  logic             blue;
  logic [PWM_W-1:0] brightness;
  logic             led_r;
  logic             led_g;
  logic             led_b;
  logic             color_chg;

  modport master (
    output enable, red, green, blue, brightness,
    input  led_r, led_g, led_b, color_chg
  );

  modport slave (
    input  enable, red, green, blue, brightness,
    output led_r, led_g, led_b, color_chg
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-stage synchronizer for inputs that carry no timing relation to clk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: PWM-dims a tricolor request onto an RGB LED, switching colour only at period ends.
// Build option: define RGB_FLASH_EN to show each new colour at full brightness for FLASH_PERIODS periods.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PWM_W         = DEF_PWM_W,
  parameter int FLASH_PERIODS = DEF_FLASH_PERIODS
) (
  input logic             clk,
  input logic             rst_n,
  rgb_pwm_driver_if.slave bus
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  rgb_t             color_sync;
  rgb_t             color_q, color_d;
  rgb_t             led_q, led_d;
  logic             color_chg_q, color_chg_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  state_t           state_q, state_d;
  logic             period_end;
  logic             color_diff;

`ifdef RGB_FLASH_EN
  localparam int FC_W = (FLASH_PERIODS > 1) ? $clog2(FLASH_PERIODS) : 1;
  localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_PERIODS - 1);

  logic [FC_W-1:0] flash_cnt_q, flash_cnt_d;
`endif

  sync_2ff #(
    .WIDTH(3)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({bus.red, bus.green, bus.blue}),
    .q    (color_sync)
  );

  always_comb begin
    period_end  = (state_q != IDLE) && (pwm_cnt_q == CNT_MAX);
    color_diff  = (color_sync != color_q);
    state_d     = state_q;
    pwm_cnt_d   = pwm_cnt_q;
    color_d     = color_q;
    color_chg_d = 1'b0;
    led_d       = 3'b000;
`ifdef RGB_FLASH_EN
    flash_cnt_d = flash_cnt_q;
`endif

    // Colour is only ever swapped between periods, so each period keeps one colour.
    if (period_end) begin
      color_d     = color_sync;
      color_chg_d = color_diff;
    end

    unique case (state_q)
      IDLE: begin
        pwm_cnt_d = '0;
`ifdef RGB_FLASH_EN
        flash_cnt_d = '0;
`endif
        if (bus.enable) begin
          state_d = ON;
        end
      end
      ON: begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        led_d     = rgb_gate(color_q, pwm_cnt_q < bus.brightness);
`ifdef RGB_FLASH_EN
        if (period_end && color_diff) begin
          state_d     = FLASH;
          flash_cnt_d = '0;
        end
`endif
      end
`ifdef RGB_FLASH_EN
      FLASH: begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        led_d     = color_q;
        if (period_end) begin
          if (color_diff) begin
            flash_cnt_d = '0;
          end else if (flash_cnt_q == FLASH_LAST) begin
            state_d     = ON;
            flash_cnt_d = '0;
          end else begin
            flash_cnt_d = flash_cnt_q + FC_W'(1);
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Disable wins over everything else and darkens the LED on the very next cycle.
    if (!bus.enable) begin
      state_d   = IDLE;
      pwm_cnt_d = '0;
      led_d     = 3'b000;
`ifdef RGB_FLASH_EN
      flash_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pwm_cnt_q   <= '0;
      color_q     <= 3'b000;
      led_q       <= 3'b000;
      color_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_cnt_q   <= pwm_cnt_d;
      color_q     <= color_d;
      led_q       <= led_d;
      color_chg_q <= color_chg_d;
    end
  end

`ifdef RGB_FLASH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end
`endif

  assign bus.led_r     = led_q[R_IDX];
  assign bus.led_g     = led_q[G_IDX];
  assign bus.led_b     = led_q[B_IDX];
  assign bus.color_chg = color_chg_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: scoreboard bench; a cycle-level behavioural model predicts every output cycle.
module tb_rgb_pwm_driver;
  import rgb_pkg::*;

  localparam int PW      = 4;
  localparam int FP      = 4;
  localparam int P       = 1 << PW;
  localparam int DUTY_HI = 4;
`ifdef RGB_FLASH_EN
  localparam int FLASH_HIGH = P * FP;
`else
  localparam int FLASH_HIGH = FP * DUTY_HI;
`endif

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  rgb_pwm_driver_if #(.PWM_W(PW)) bus ();

  rgb_pwm_driver #(
    .PWM_W        (PW),
    .FLASH_PERIODS(FP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  function automatic int outs();
    return int'({bus.led_r, bus.led_g, bus.led_b, bus.color_chg});
  endfunction

  // Reference model: an LED period is P cycles from when driving starts; the colour
  // seen two edges late is adopted at the last cycle of a period; a new colour is
  // shown solid for FP whole periods when flashing is built in.
  logic [3:0] exp_q[$];
  logic [2:0] hist[$];
  logic [2:0] col = 3'b000;
  logic [2:0] syncd, led_e;
  logic       chg_e;
  bit         running = 0;
  int         phase = 0;
  int         flash_left = 0;
  logic [3:0] exp_v;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        hist.delete();
        running    = 0;
        phase      = 0;
        flash_left = 0;
        col        = 3'b000;
      end else begin
        syncd = (hist.size() == 2) ? hist[0] : 3'b000;
        hist.push_back({bus.red, bus.green, bus.blue});
        if (hist.size() > 2) void'(hist.pop_front());
        led_e = 3'b000;
        chg_e = 1'b0;
        if (!running) begin
          if (bus.enable) begin
            running = 1;
            phase   = 0;
          end
        end else begin
          if (flash_left > 0 || phase < int'(bus.brightness)) led_e = col;
          if (phase == P - 1) begin
            if (syncd != col) begin
              chg_e = 1'b1;
              col   = syncd;
`ifdef RGB_FLASH_EN
              flash_left = FP;
`endif
            end else if (flash_left > 0) begin
              flash_left--;
            end
          end
          phase = (phase + 1) % P;
          if (!bus.enable) begin
            running    = 0;
            phase      = 0;
            flash_left = 0;
            led_e      = 3'b000;
          end
        end
        exp_q.push_back({led_e, chg_e});
      end
    end
  end

  // Monitor: one registered output word per clock, compared half a cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("cycle_out", outs(), int'(exp_v));
      end
    end
  end

  task automatic set_color(input logic [2:0] c);
    {bus.red, bus.green, bus.blue} = c;
  endtask

  task automatic count_high(input int n, output int cr, output int cg, output int cb);
    cr = 0;
    cg = 0;
    cb = 0;
    repeat (n) begin
      @(negedge clk);
      cr += int'(bus.led_r);
      cg += int'(bus.led_g);
      cb += int'(bus.led_b);
    end
  endtask

  task automatic wait_chg(input string name);
    int cyc;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.color_chg) break;
    end
    check(name, int'(bus.color_chg), 1);
  endtask

  int cr, cg, cb;
  int nseg;

  initial begin
    rst_n          = 1'b0;
    bus.enable     = 1'b1;
    bus.brightness = PW'(DUTY_HI);
    set_color(3'b100);
    repeat (3) @(negedge clk);
    check("rst_outs", outs(), 0);
    check("rst_state", int'(dut.state_q), int'(IDLE));
    rst_n = 1'b1;
    $display("[TB] reset held with enable=1 red=1, released");

    repeat (5) @(negedge clk);
    set_color(3'b010);
    repeat (200) @(negedge clk);
    count_high(64, cr, cg, cb);
    check("dim_g", cg, 4 * DUTY_HI);
    check("dim_r", cr, 0);
    check("dim_b", cb, 0);
    $display("[TB] dimming green b=4: r=%0d g=%0d b=%0d over 64", cr, cg, cb);

    set_color(3'b001);
    wait_chg("chg_blue");
    count_high(64, cr, cg, cb);
    check("flash_b", cb, FLASH_HIGH);
    check("flash_g", cg, 0);
    count_high(16, cr, cg, cb);
    check("post_flash_b", cb, DUTY_HI);
    $display("[TB] green->blue: blue high %0d in post-flash period", cb);

    set_color(3'b010);
    wait_chg("chg_green");
    repeat (20) @(negedge clk);
    set_color(3'b100);
    wait_chg("chg_red");
    count_high(64, cr, cg, cb);
    check("retrig_r", cr, FLASH_HIGH);
    check("retrig_g", cg, 0);
    $display("[TB] retrigger red: red high %0d of 64", cr);

    set_color(3'b010);
    bus.brightness = '0;
    repeat (150) @(negedge clk);
    count_high(32, cr, cg, cb);
    check("bri0_g", cg, 0);
    bus.brightness = PW'(P - 1);
    repeat (20) @(negedge clk);
    count_high(32, cr, cg, cb);
    check("bri15_g", cg, 2 * (P - 1));
    $display("[TB] edge duties: brightness 15 gives %0d of 32", cg);

    set_color(3'b000);
    repeat (150) @(negedge clk);
    count_high(32, cr, cg, cb);
    check("black", cr + cg + cb, 0);
    $display("[TB] all-zero colour: %0d lit cycles", cr + cg + cb);

    set_color(3'b110);
    repeat (45) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("dis_leds", outs() >> 1, 0);
    check("dis_cnt", int'(dut.pwm_cnt_q), 0);
    check("dis_state", int'(dut.state_q), int'(IDLE));
    repeat (8) @(negedge clk);
    bus.enable = 1'b1;
    repeat (40) @(negedge clk);
    $display("[TB] disable mid-period then re-enable");

    set_color(3'b001);
    wait_chg("chg_pre_rst");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midflash_rst_outs", outs(), 0);
    check("midflash_rst_state", int'(dut.state_q), int'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    $display("[TB] reset during flash, restart from power-up");

    for (int s = 0; s < 40; s++) begin
      bus.enable     = ($urandom_range(9) != 0);
      bus.brightness = PW'($urandom_range(P - 1));
      set_color(3'($urandom_range(7)));
      nseg = int'($urandom_range(150, 5));
      repeat (nseg) @(negedge clk);
      $display("[TB] seg %0d en=%0d col=%b%b%b bri=%0d cycles=%0d", s, bus.enable,
               bus.red, bus.green, bus.blue, bus.brightness, nseg);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rgb_pwm_driver.md
RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver
Downstream stage: consumes the tricolor red/green/blue outputs and drives a PWM-dimmed RGB LED.

Interface
REQ-001 SHALL have parameter PWM_W, default 4, PWM counter width; period = 2^PWM_W cycles.
REQ-002 SHALL have parameter FLASH_PERIODS, default 4, number of full-brightness PWM periods after a colour change.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  1 = drive LED; 0 = idle, outputs dark.
REQ-006 SHALL have ports red, green, blue  input  1 each  colour request from the tricolor stage; asynchronous to clk.
REQ-007 SHALL have port brightness  input  PWM_W  steady-state duty; synchronous to clk.
REQ-008 SHALL have ports led_r, led_g, led_b  output  1 each  registered PWM drive.
REQ-009 SHALL have port color_chg  output  1  one-cycle pulse when the latched colour changes.

Function
REQ-010 SHALL pass {red,green,blue} through a 2-flop synchronizer; only synchronized bits are used internally.
REQ-011 SHALL keep pwm_cnt (PWM_W bits), incrementing every cycle in ON/FLASH, wrapping max->0; period_end = (pwm_cnt == max).
REQ-012 SHALL load color_q from the synchronized colour only on period_end, so no PWM period is ever truncated.
REQ-013 SHALL pulse color_chg for exactly the cycle after period_end when the loaded value differs from the previous color_q.
REQ-014 SHALL implement FSM IDLE/ON/FLASH: IDLE->ON on the cycle after enable=1; ON->FLASH on a colour change at period_end; FLASH->ON after FLASH_PERIODS period_ends; any state->IDLE on the cycle after enable=0.
REQ-015 In ON, SHALL drive each led_x = color_q[x] AND (pwm_cnt < brightness); brightness 0 = always dark, brightness max = on (2^PWM_W-1)/2^PWM_W.
REQ-016 In FLASH, SHALL drive each led_x = color_q[x] constantly.
REQ-017 In IDLE, SHALL hold pwm_cnt and flash_cnt at 0, drive all led_x = 0, retain color_q.
REQ-018 SHALL restart flash_cnt at 0 and stay in FLASH if a further change occurs at a period_end during FLASH.
REQ-019 SHALL pass multi-bit colour combinations (e.g. red&green) unchanged; all-zero gives dark LEDs in all states.
REQ-020 SHALL have input-to-color_q latency of 2 sync cycles plus up to 2^PWM_W cycles to the next period_end.
REQ-021 SHALL sample brightness every cycle; a change takes effect in the next cycle's compare.

Reset
REQ-022 On rst_n=0, SHALL asynchronously clear synchronizer, pwm_cnt, flash_cnt, color_q, led_r/g/b, color_chg to 0 and set state to IDLE.
REQ-023 Reset asserted mid-FLASH SHALL abandon the flash; after release, behaviour SHALL be as from power-up.

Configuration
REQ-024 SHALL use macro RGB_FLASH_EN: defined -> REQ-014/016/018 flash behaviour present; undefined -> no FLASH state, colour changes load color_q and stay in ON, color_chg still pulses.

Structure
REQ-025 SHALL put state enum (IDLE, ON, FLASH) and the default PWM_W/FLASH_PERIODS constants in shared package rgb_pkg.
REQ-026 SHALL place the 2-flop synchronizer in sub-module sync_2ff (parameterised width, clk, rst_n), instanced once with width 3.

Verification
REQ-027 Reset: rst_n=0 while enable=1, red=1 -> all outputs 0, state IDLE; release -> led_* stay 0 until enable observed.
REQ-028 Dimming: enable=1, green=1, brightness=4, no changes -> led_g high exactly 4 of every 16 cycles, led_r=led_b=0.
REQ-029 Flash (RGB_FLASH_EN): green->blue -> color_chg one pulse at period boundary, led_b constant high 64 cycles, then 4/16 duty.
REQ-030 Re-trigger: second change red during flash -> flash restarts, led_r high 64 cycles after that boundary.
REQ-031 Edge duties: brightness=0 -> led_* never high in ON; brightness=15 -> high 15 of 16 cycles.
REQ-032 Disable: enable=0 mid-period -> next cycle led_*=0, pwm_cnt=0; re-enable -> PWM restarts from count 0 with retained color_q.
